dcache_arbiter: RTL and testbench
=================================

DCACHE_ARBITER -- requirements
Module: dcache_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, shall be the data word width.
REQ-002 Parameter ADDR_W, default 4, shall be the dcache address width.
REQ-003 Parameter MAX_HOLD, default 4, shall be the maximum number of consecutive accesses per grant when another requester is pending.
REQ-004 Parameter STARVE_LIM, default 8, shall be the number of denied display-request cycles that forces a display grant.
REQ-005 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Ports spi_req_in, spi_wen_in, input, 1 each: request and write-enable from the SPI loader.
REQ-008 Ports spi_addr_in (ADDR_W) and spi_data_in (DATA_W), input: SPI loader address and write data.
REQ-009 Ports proc_req_in, proc_wen_in, proc_addr_in and proc_data_in, input, same widths: processor requester.
REQ-010 Ports disp_req_in (1) and disp_addr_in (ADDR_W), input: seven-segment read-only requester.
REQ-011 Ports spi_gnt_out, proc_gnt_out, disp_gnt_out, output, 1 each: registered grants, one-hot or all zero.
REQ-012 Ports spi_ack_out, proc_ack_out, disp_ack_out, output, 1 each: one-cycle completion pulses.
REQ-013 Port rd_data_out, output, DATA_W: registered read data, valid while any ack is high.
REQ-014 Ports mem_en_out and mem_wen_out (1 each), mem_addr_out (ADDR_W) and mem_data_out (DATA_W), output: dcache port.
REQ-015 Port mem_rdata_in, input, DATA_W: combinational dcache read data.
REQ-016 Port owner_out, output, 2: 0 = none, 1 = spi, 2 = proc, 3 = disp.

Function
REQ-017 The FSM shall have states IDLE and OWN; an owner register holds the granted requester.
REQ-018 In IDLE, when at least one request is high, the FSM shall select an owner and enter OWN on the next edge; the grant shall assert in the first OWN cycle.
REQ-019 Selection priority shall be spi > proc > disp, except that disp shall win when starve_cnt == STARVE_LIM.
REQ-020 In OWN, each cycle in which the owner's req is high shall be one access: mem_en_out = 1 and the owner's addr/data/wen are driven combinationally (disp wen = 0).
REQ-021 Outside an access, mem_en_out and mem_wen_out shall be 0 and mem_addr_out/mem_data_out shall be 0.
REQ-022 On each access, mem_rdata_in shall be registered into rd_data_out, and the owner's ack shall pulse on the following cycle (latency 1), for both reads and writes.
REQ-023 hold_cnt shall count accesses in the current grant; it shall clear on entry to OWN.
REQ-024 The grant shall be released (OWN -> IDLE, grant deasserted next cycle) when the owner's req is low in an OWN cycle.
REQ-025 The grant shall also be released after the access that brings hold_cnt to MAX_HOLD, if any other request is high in that cycle; otherwise hold_cnt shall saturate and the grant shall continue.
REQ-026 After any release, at least one IDLE bubble cycle shall occur before the next grant; a released owner still requesting competes normally.
REQ-027 starve_cnt shall increment, saturating at STARVE_LIM, each cycle that disp_req_in = 1 and disp is not the owner; it shall clear when disp is granted or disp_req_in = 0.
REQ-028 Simultaneous requests in IDLE shall be resolved by REQ-019 only; requests arriving during OWN shall wait.
REQ-029 A requester dropping req mid-grant shall receive no ack for that cycle.
REQ-030 Address/data changes from the owner shall take effect the same cycle; there shall be no buffering of requests.

Reset
REQ-031 While rst = 1, the state shall be IDLE and all grants, acks, mem_en_out, mem_wen_out, owner_out, rd_data_out, hold_cnt and starve_cnt shall be 0 on the next edge.
REQ-032 Reset asserted mid-grant shall abort the access: no ack shall pulse after the reset edge, and the memory shall not be written in any cycle where rst = 1.

Verification
REQ-033 spi_req_in and proc_req_in are raised together in IDLE -> spi_gnt_out is 1 in cycle 2; proc waits until the spi grant is released and a bubble cycle passes.
REQ-034 proc holds a write to addr 0x3, data 0xA5, while spi_req_in = 1 -> exactly 4 accesses occur, then release and a bubble, then spi_gnt_out = 1.
REQ-035 disp_req_in is held high while spi and proc alternate requests -> after 8 denied cycles, disp is granted at the next IDLE regardless of spi/proc.
REQ-036 disp reads addr 0x9 with mem_rdata_in = 0x3C -> disp_ack_out = 1 with rd_data_out = 0x3C one cycle after the access.
REQ-037 rst is asserted during a proc write burst -> all outputs are 0 on the next edge, no ack pulses, and mem_wen_out = 0 during reset.
REQ-038 A single requester holds req for 10 cycles with no contention -> 10 consecutive accesses with no release.

Source files
------------

// File: rtl/dcache_arbiter_if.sv
// Bus bundle between the dcache arbiter and its three requesters plus the dcache port.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface dcache_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              spi_req_in;
    logic              spi_wen_in;
    logic [ADDR_W-1:0] spi_addr_in;
    logic [DATA_W-1:0] spi_data_in;
    logic              proc_req_in;
    logic              proc_wen_in;
    logic [ADDR_W-1:0] proc_addr_in;
    logic [DATA_W-1:0] proc_data_in;
    logic              disp_req_in;
    logic [ADDR_W-1:0] disp_addr_in;
    logic              spi_gnt_out;
    logic              proc_gnt_out;
    logic              disp_gnt_out;
    logic              spi_ack_out;
    logic              proc_ack_out;
    logic              disp_ack_out;
    logic [DATA_W-1:0] rd_data_out;
    logic              mem_en_out;
    logic              mem_wen_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_rdata_in;
    logic [1:0]        owner_out;

    modport slave (
        input  spi_req_in, spi_wen_in, spi_addr_in, spi_data_in,
        input  proc_req_in, proc_wen_in, proc_addr_in, proc_data_in,
        input  disp_req_in, disp_addr_in, mem_rdata_in,
        output spi_gnt_out, proc_gnt_out, disp_gnt_out,
        output spi_ack_out, proc_ack_out, disp_ack_out, rd_data_out,
        output mem_en_out, mem_wen_out, mem_addr_out, mem_data_out, owner_out
    );

    modport master (
        output spi_req_in, spi_wen_in, spi_addr_in, spi_data_in,
        output proc_req_in, proc_wen_in, proc_addr_in, proc_data_in,
        output disp_req_in, disp_addr_in, mem_rdata_in,
        input  spi_gnt_out, proc_gnt_out, disp_gnt_out,
        input  spi_ack_out, proc_ack_out, disp_ack_out, rd_data_out,
        input  mem_en_out, mem_wen_out, mem_addr_out, mem_data_out, owner_out
    );
endinterface

// File: rtl/dcache_arbiter.sv
// Three-way dcache arbiter (SPI loader, processor, seven-segment display) with
// fixed priority, a per-grant hold limit under contention and display anti-starvation.
module dcache_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int MAX_HOLD   = 4,
    parameter int STARVE_LIM = 8
) (
    input logic              clk,
    input logic              rst,
    dcache_arbiter_if.slave  bus
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int STV_W  = $clog2(STARVE_LIM + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_LIM);

    typedef enum logic {IDLE, OWN} state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SPI  = 2'd1,
        OWN_PROC = 2'd2,
        OWN_DISP = 2'd3
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic [2:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              owner_req, others_req, any_req, access;
    logic              mem_en, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    always_comb begin
        owner_req  = 1'b0;
        others_req = 1'b0;
        case (owner_q)
            OWN_SPI: begin
                owner_req  = bus.spi_req_in;
                others_req = bus.proc_req_in | bus.disp_req_in;
            end
            OWN_PROC: begin
                owner_req  = bus.proc_req_in;
                others_req = bus.spi_req_in | bus.disp_req_in;
            end
            OWN_DISP: begin
                owner_req  = bus.disp_req_in;
                others_req = bus.spi_req_in | bus.proc_req_in;
            end
            default: ;
        endcase
    end

    assign any_req  = bus.spi_req_in | bus.proc_req_in | bus.disp_req_in;
    // Reset suppresses the access outright so nothing is written while rst is high.
    assign access   = (state_q == OWN) && owner_req && !rst;
    assign hold_inc = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HOLD_W'(1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        ack_d     = '0;
        rd_data_d = rd_data_q;
        mem_en    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = OWN;
                    hold_d  = '0;
                    if (bus.disp_req_in && starve_q == STV_MAX) owner_d = OWN_DISP;
                    else if (bus.spi_req_in)                    owner_d = OWN_SPI;
                    else if (bus.proc_req_in)                   owner_d = OWN_PROC;
                    else                                        owner_d = OWN_DISP;
                end
            end
            OWN: begin
                if (access) begin
                    mem_en    = 1'b1;
                    hold_d    = hold_inc;
                    rd_data_d = bus.mem_rdata_in;
                    case (owner_q)
                        OWN_SPI: begin
                            mem_wen  = bus.spi_wen_in;
                            mem_addr = bus.spi_addr_in;
                            mem_data = bus.spi_data_in;
                            ack_d[0] = 1'b1;
                        end
                        OWN_PROC: begin
                            mem_wen  = bus.proc_wen_in;
                            mem_addr = bus.proc_addr_in;
                            mem_data = bus.proc_data_in;
                            ack_d[1] = 1'b1;
                        end
                        OWN_DISP: begin
                            mem_addr = bus.disp_addr_in;
                            ack_d[2] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Release on a dropped request, or once the hold budget is spent while others wait.
                if (!owner_req || (hold_inc == HOLD_MAX && others_req)) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!bus.disp_req_in || owner_q == OWN_DISP || owner_d == OWN_DISP) starve_d = '0;
        else if (starve_q == STV_MAX)                                       starve_d = starve_q;
        else                                                                starve_d = starve_q + STV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_NONE;
            hold_q    <= '0;
            starve_q  <= '0;
            ack_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            starve_q  <= starve_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    // owner_q is only non-zero while in OWN, so the grants follow it directly.
    assign bus.spi_gnt_out  = (owner_q == OWN_SPI);
    assign bus.proc_gnt_out = (owner_q == OWN_PROC);
    assign bus.disp_gnt_out = (owner_q == OWN_DISP);
    assign bus.owner_out    = owner_q;
    assign bus.spi_ack_out  = ack_q[0];
    assign bus.proc_ack_out = ack_q[1];
    assign bus.disp_ack_out = ack_q[2];
    assign bus.rd_data_out  = rd_data_q;
    assign bus.mem_en_out   = mem_en;
    assign bus.mem_wen_out  = mem_wen;
    assign bus.mem_addr_out = mem_addr;
    assign bus.mem_data_out = mem_data;

endmodule

// File: tb/tb_dcache_arbiter.sv
// Self-checking bench for dcache_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural owner/hold/starvation model.
module tb_dcache_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int MH = 4;
    localparam int SL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dcache_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_HOLD(MH), .STARVE_LIM(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: current owner (0 none, 1 spi, 2 proc, 3 disp), accesses this grant,
    // denied display cycles, which ack is due, and the latched read word.
    int          m_own    = 0;
    int          m_hold   = 0;
    int          m_starve = 0;
    int          m_ack    = 0;
    logic [DW-1:0] m_rd   = '0;

    function automatic bit req_of(int o);
        case (o)
            1: return bus.spi_req_in;
            2: return bus.proc_req_in;
            3: return bus.disp_req_in;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model_blk
        int own_n, hold_n, starve_n, ack_n;
        logic [DW-1:0] rd_n;
        bit acc, others;
        if (rst) begin
            own_n = 0; hold_n = 0; starve_n = 0; ack_n = 0; rd_n = '0;
        end else begin
            own_n = m_own; hold_n = m_hold; ack_n = 0; rd_n = m_rd;
            if (m_own == 0) begin
                if (bus.spi_req_in || bus.proc_req_in || bus.disp_req_in) begin
                    hold_n = 0;
                    if (bus.disp_req_in && m_starve == SL) own_n = 3;
                    else if (bus.spi_req_in)               own_n = 1;
                    else if (bus.proc_req_in)              own_n = 2;
                    else                                   own_n = 3;
                end
            end else begin
                acc    = req_of(m_own);
                others = (bus.spi_req_in && m_own != 1) || (bus.proc_req_in && m_own != 2) ||
                         (bus.disp_req_in && m_own != 3);
                if (acc) begin
                    ack_n  = m_own;
                    rd_n   = bus.mem_rdata_in;
                    hold_n = (m_hold + 1 > MH) ? MH : m_hold + 1;
                end
                if (!acc) own_n = 0;
                else if (hold_n == MH && others) own_n = 0;
            end
            if (!bus.disp_req_in || m_own == 3 || own_n == 3) starve_n = 0;
            else starve_n = (m_starve + 1 > SL) ? SL : m_starve + 1;
        end
        m_own    <= own_n;
        m_hold   <= hold_n;
        m_starve <= starve_n;
        m_ack    <= ack_n;
        m_rd     <= rd_n;
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.spi_req_in   = 1'b0; bus.spi_wen_in  = 1'b0; bus.spi_addr_in  = '0; bus.spi_data_in  = '0;
        bus.proc_req_in  = 1'b0; bus.proc_wen_in = 1'b0; bus.proc_addr_in = '0; bus.proc_data_in = '0;
        bus.disp_req_in  = 1'b0; bus.disp_addr_in = '0;  bus.mem_rdata_in = '0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (3) next_cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) next_cyc();
        checks++;
        if ({bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out} !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b want=000", {bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out});
        end
        checks++;
        if ({bus.spi_ack_out, bus.proc_ack_out, bus.disp_ack_out, bus.mem_en_out, bus.mem_wen_out} !== 5'b0) begin
            failures++; $display("FAIL reset_ack_mem got=%b want=00000",
                {bus.spi_ack_out, bus.proc_ack_out, bus.disp_ack_out, bus.mem_en_out, bus.mem_wen_out});
        end
        checks++;
        if (bus.owner_out !== 2'd0 || bus.rd_data_out !== 8'h00) begin
            failures++; $display("FAIL reset_owner_rd got owner=%0d rd=%h want 0/00", bus.owner_out, bus.rd_data_out);
        end
        rst = 1'b0;
        next_cyc();
        checks++;
        if (bus.owner_out !== 2'd0) begin
            failures++; $display("FAIL post_reset_idle got owner=%0d want=0", bus.owner_out);
        end
    endtask

    task automatic test_simultaneous();
        bus.spi_req_in = 1'b1; bus.spi_addr_in = 4'h1;
        bus.proc_req_in = 1'b1; bus.proc_addr_in = 4'h2;
        #1;
        checks++;
        if (bus.spi_gnt_out !== 1'b0) begin
            failures++; $display("FAIL simul_cycle1_gnt got=%b want=0", bus.spi_gnt_out);
        end
        next_cyc();
        checks++;
        if ({bus.spi_gnt_out, bus.proc_gnt_out} !== 2'b10) begin
            failures++; $display("FAIL simul_cycle2_gnt got=%b want=10", {bus.spi_gnt_out, bus.proc_gnt_out});
        end
        next_cyc();
        bus.spi_req_in = 1'b0;
        #1;
        checks++;
        if ({bus.spi_gnt_out, bus.mem_en_out, bus.spi_ack_out} !== 3'b101) begin
            failures++; $display("FAIL simul_release_cycle got gnt/en/ack=%b want=101",
                {bus.spi_gnt_out, bus.mem_en_out, bus.spi_ack_out});
        end
        next_cyc();
        checks++;
        if ({bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out, bus.spi_ack_out} !== 4'b0000) begin
            failures++; $display("FAIL simul_bubble got=%b want=0000",
                {bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out, bus.spi_ack_out});
        end
        next_cyc();
        checks++;
        if (bus.proc_gnt_out !== 1'b1 || bus.mem_addr_out !== 4'h2) begin
            failures++; $display("FAIL simul_proc_gnt got gnt=%b addr=%h want 1/2", bus.proc_gnt_out, bus.mem_addr_out);
        end
        settle();
    endtask

    task automatic test_hold_limit();
        int accesses = 0;
        int acks = 0;
        bus.proc_req_in = 1'b1; bus.proc_wen_in = 1'b1; bus.proc_addr_in = 4'h3; bus.proc_data_in = 8'hA5;
        next_cyc();
        bus.spi_req_in = 1'b1; bus.spi_addr_in = 4'hE;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (bus.proc_gnt_out && bus.mem_en_out && bus.mem_wen_out &&
                bus.mem_addr_out == 4'h3 && bus.mem_data_out == 8'hA5) accesses++;
            if (bus.proc_ack_out) acks++;
            if (i == 4) begin
                checks++;
                if ({bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out} !== 3'b000) begin
                    failures++; $display("FAIL hold_bubble got=%b want=000",
                        {bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out});
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.spi_gnt_out !== 1'b1) begin
                    failures++; $display("FAIL hold_spi_after got=%b want=1", bus.spi_gnt_out);
                end
            end
            next_cyc();
        end
        checks++;
        if (accesses !== 4) begin
            failures++; $display("FAIL hold_access_count got=%0d want=4", accesses);
        end
        checks++;
        if (acks !== 4) begin
            failures++; $display("FAIL hold_ack_count got=%0d want=4", acks);
        end
        settle();
    endtask

    task automatic test_starvation();
        int first = -1;
        bus.spi_req_in = 1'b1; bus.proc_req_in = 1'b1; bus.disp_req_in = 1'b1; bus.disp_addr_in = 4'h7;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.disp_gnt_out && first < 0) begin
                first = i;
                checks++;
                if ({bus.mem_en_out, bus.mem_wen_out} !== 2'b10 || bus.mem_addr_out !== 4'h7) begin
                    failures++; $display("FAIL starve_disp_access got en/wen=%b addr=%h want 10/7",
                        {bus.mem_en_out, bus.mem_wen_out}, bus.mem_addr_out);
                end
            end
            next_cyc();
        end
        checks++;
        if (first !== 11) begin
            failures++; $display("FAIL starve_grant_cycle got=%0d want=11", first);
        end
        settle();
    endtask

    task automatic test_disp_read();
        bus.disp_req_in = 1'b1; bus.disp_addr_in = 4'h9;
        next_cyc();
        bus.mem_rdata_in = 8'h3C;
        #1;
        checks++;
        if ({bus.disp_gnt_out, bus.mem_en_out, bus.mem_wen_out} !== 3'b110 || bus.mem_addr_out !== 4'h9) begin
            failures++; $display("FAIL disp_access got gnt/en/wen=%b addr=%h want 110/9",
                {bus.disp_gnt_out, bus.mem_en_out, bus.mem_wen_out}, bus.mem_addr_out);
        end
        next_cyc();
        bus.disp_req_in = 1'b0; bus.mem_rdata_in = 8'h00;
        #1;
        checks++;
        if (bus.disp_ack_out !== 1'b1 || bus.rd_data_out !== 8'h3C) begin
            failures++; $display("FAIL disp_ack got ack=%b rd=%h want 1/3c", bus.disp_ack_out, bus.rd_data_out);
        end
        checks++;
        if (bus.mem_en_out !== 1'b0) begin
            failures++; $display("FAIL disp_dropped_no_access got=%b want=0", bus.mem_en_out);
        end
        next_cyc();
        checks++;
        if (bus.disp_ack_out !== 1'b0) begin
            failures++; $display("FAIL disp_ack_pulse got=%b want=0", bus.disp_ack_out);
        end
        settle();
    endtask

    task automatic test_reset_mid_burst();
        bus.proc_req_in = 1'b1; bus.proc_wen_in = 1'b1; bus.proc_addr_in = 4'h5; bus.proc_data_in = 8'h77;
        bus.mem_rdata_in = 8'h5A;
        repeat (3) next_cyc();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_en_out, bus.mem_wen_out} !== 2'b00) begin
            failures++; $display("FAIL rstmid_no_write got en/wen=%b want=00", {bus.mem_en_out, bus.mem_wen_out});
        end
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            checks++;
            if ({bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out, bus.spi_ack_out, bus.proc_ack_out,
                 bus.disp_ack_out, bus.mem_en_out, bus.mem_wen_out} !== 8'h00 ||
                bus.owner_out !== 2'd0 || bus.rd_data_out !== 8'h00) begin
                failures++; $display("FAIL rstmid_outputs cycle=%0d got gnt=%b ack=%b en=%b wen=%b owner=%0d rd=%h want all 0", i,
                    {bus.spi_gnt_out, bus.proc_gnt_out, bus.disp_gnt_out},
                    {bus.spi_ack_out, bus.proc_ack_out, bus.disp_ack_out},
                    bus.mem_en_out, bus.mem_wen_out, bus.owner_out, bus.rd_data_out);
            end
        end
        rst = 1'b0;
        bus.proc_req_in = 1'b0;
        next_cyc();
        checks++;
        if (bus.proc_ack_out !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_late_ack got=%b want=0", bus.proc_ack_out);
        end
        settle();
    endtask

    task automatic test_long_hold();
        int accesses = 0;
        bus.spi_req_in = 1'b1;
        next_cyc();
        for (int i = 0; i < 10; i++) begin
            bus.spi_addr_in = AW'(i);
            bus.spi_data_in = DW'($urandom);
            #1;
            if (bus.spi_gnt_out && bus.mem_en_out && bus.mem_addr_out == AW'(i) &&
                bus.mem_data_out == bus.spi_data_in) accesses++;
            next_cyc();
        end
        checks++;
        if (accesses !== 10) begin
            failures++; $display("FAIL long_hold_accesses got=%0d want=10", accesses);
        end
        settle();
    endtask

    task automatic test_random();
        logic [2:0]    exp_gnt, exp_ack;
        logic          exp_acc, exp_wen;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.spi_req_in   = ($urandom_range(0, 2) == 0);
            bus.proc_req_in  = ($urandom_range(0, 1) == 0);
            bus.disp_req_in  = ($urandom_range(0, 2) != 0);
            bus.spi_wen_in   = $urandom_range(0, 1);
            bus.proc_wen_in  = $urandom_range(0, 1);
            bus.spi_addr_in  = AW'($urandom);
            bus.proc_addr_in = AW'($urandom);
            bus.disp_addr_in = AW'($urandom);
            bus.spi_data_in  = DW'($urandom);
            bus.proc_data_in = DW'($urandom);
            bus.mem_rdata_in = DW'($urandom);
            #1;
            exp_gnt  = {m_own == 3, m_own == 2, m_own == 1};
            exp_ack  = {m_ack == 3, m_ack == 2, m_ack == 1};
            exp_acc  = !rst && m_own != 0 && req_of(m_own);
            exp_wen  = exp_acc && ((m_own == 1 && bus.spi_wen_in) || (m_own == 2 && bus.proc_wen_in));
            exp_addr = !exp_acc ? '0 : (m_own == 1) ? bus.spi_addr_in : (m_own == 2) ? bus.proc_addr_in : bus.disp_addr_in;
            exp_data = !exp_acc ? '0 : (m_own == 1) ? bus.spi_data_in : (m_own == 2) ? bus.proc_data_in : '0;
            checks++;
            if ({bus.disp_gnt_out, bus.proc_gnt_out, bus.spi_gnt_out} !== exp_gnt) begin
                failures++; $display("FAIL rand_gnt i=%0d got=%b want=%b", i,
                    {bus.disp_gnt_out, bus.proc_gnt_out, bus.spi_gnt_out}, exp_gnt);
            end
            checks++;
            if ({bus.disp_ack_out, bus.proc_ack_out, bus.spi_ack_out} !== exp_ack) begin
                failures++; $display("FAIL rand_ack i=%0d got=%b want=%b", i,
                    {bus.disp_ack_out, bus.proc_ack_out, bus.spi_ack_out}, exp_ack);
            end
            checks++;
            if (bus.rd_data_out !== m_rd || bus.owner_out !== 2'(m_own)) begin
                failures++; $display("FAIL rand_rd_owner i=%0d got rd=%h owner=%0d want rd=%h owner=%0d", i,
                    bus.rd_data_out, bus.owner_out, m_rd, m_own);
            end
            checks++;
            if ({bus.mem_en_out, bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out} !==
                {exp_acc, exp_wen, exp_addr, exp_data}) begin
                failures++; $display("FAIL rand_mem i=%0d got en=%b wen=%b a=%h d=%h want en=%b wen=%b a=%h d=%h", i,
                    bus.mem_en_out, bus.mem_wen_out, bus.mem_addr_out, bus.mem_data_out,
                    exp_acc, exp_wen, exp_addr, exp_data);
            end
            next_cyc();
        end
        rst = 1'b0;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_simultaneous();
        test_hold_limit();
        test_starvation();
        test_disp_read();
        test_reset_mid_burst();
        test_long_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
